// File: rtl/fft_w8_twiddle_stage.sv
// fft_w8_twiddle_stage
// Radix-2 8-point FFT twiddle rotation stage. Each sample in a frame of eight
// gets index n. Samples 0..3 pass through unchanged. Samples 4..7 are rotated
// by W8^k with k = n-4.
// Three pipeline stages: S1 forms re+im / im-re, S2 applies the 1/sqrt(2)
// constant (2896/4096), and S3 saturates and registers the output.
// A single global enable advances every stage together. This gives
// valid/ready flow control without skid buffers.
module fft_w8_twiddle_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        frame_start,
  input  logic [15:0] in_re,
  input  logic [15:0] in_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_re,
  output logic [15:0] out_im
);

  // c*x in sign-magnitude form: |x|*2896 >> 12, truncated toward zero,
  // then the sign of x is re-applied. |x| can reach 65536, so the magnitude
  // is 17 bits wide and the product is 29 bits wide. The result magnitude is
  // at most 46336, which fits a 17-bit signed value.
  function automatic logic [16:0] cmul(input logic [16:0] x);
    logic [16:0] mag;
    logic [28:0] prod;
    logic [16:0] shr;
    mag  = x[16] ? (17'd0 - x) : x;
    prod = {12'd0, mag} * 29'd2896;
    shr  = prod[28:12];
    cmul = x[16] ? (17'd0 - shr) : shr;
  endfunction

  // Exact 17-bit two's complement negation.
  function automatic logic [16:0] neg17(input logic [16:0] x);
    neg17 = 17'd0 - x;
  endfunction

  // Clamp a 17-bit signed value into the 16-bit range.
  function automatic logic [15:0] sat16(input logic [16:0] v);
    if (v[16] != v[15]) begin
      sat16 = v[16] ? 16'h8000 : 16'h7fff;
    end else begin
      sat16 = v[15:0];
    end
  endfunction

  logic        en;
  logic        accept;
  logic [2:0]  idx;

  logic [2:0]  n_q, n_d;

  logic        v1_q, v1_d;
  logic [1:0]  k1_q, k1_d;
  logic [16:0] sum1_q, sum1_d;
  logic [16:0] diff1_q, diff1_d;
  logic [15:0] re1_q, re1_d;
  logic [15:0] im1_q, im1_d;

  logic        v2_q, v2_d;
  logic [16:0] re2_q, re2_d;
  logic [16:0] im2_q, im2_d;

  logic        v3_q, v3_d;
  logic [15:0] ore_q, ore_d;
  logic [15:0] oim_q, oim_d;

  // The pipeline may advance when the output slot is empty or is being
  // consumed this cycle.
  assign en        = out_ready | ~v3_q;
  assign in_ready  = en;
  assign accept    = in_valid & en;
  assign out_valid = v3_q;
  assign out_re    = ore_q;
  assign out_im    = oim_q;

  // Frame index: frame_start forces the accepted sample to index 0.
  always_comb begin
    idx = n_q;
    n_d = n_q;
    if (accept) begin
      if (frame_start) begin
        idx = 3'd0;
      end else begin
        idx = n_q;
      end
      n_d = idx + 3'd1;
    end else begin
      n_d = n_q;
    end
  end

  // S1: capture the sample, its twiddle index and the 17-bit sum/difference.
  always_comb begin
    v1_d    = v1_q;
    k1_d    = k1_q;
    sum1_d  = sum1_q;
    diff1_d = diff1_q;
    re1_d   = re1_q;
    im1_d   = im1_q;
    if (en) begin
      v1_d    = in_valid;
      k1_d    = idx[2] ? idx[1:0] : 2'd0;
      sum1_d  = {in_re[15], in_re} + {in_im[15], in_im};
      diff1_d = {in_im[15], in_im} - {in_re[15], in_re};
      re1_d   = in_re;
      im1_d   = in_im;
    end else begin
      v1_d = v1_q;
    end
  end

  // S2: select the rotation for k. k=0 and k=2 need no multiply, but they
  // still pass through this stage so that the latency stays the same.
  always_comb begin
    v2_d  = v2_q;
    re2_d = re2_q;
    im2_d = im2_q;
    if (en) begin
      v2_d = v1_q;
      case (k1_q)
        2'd0: begin
          re2_d = {re1_q[15], re1_q};
          im2_d = {im1_q[15], im1_q};
        end
        2'd1: begin
          re2_d = cmul(sum1_q);
          im2_d = cmul(diff1_q);
        end
        2'd2: begin
          re2_d = {im1_q[15], im1_q};
          im2_d = neg17({re1_q[15], re1_q});
        end
        2'd3: begin
          re2_d = cmul(diff1_q);
          im2_d = neg17(cmul(sum1_q));
        end
        default: begin
          re2_d = {re1_q[15], re1_q};
          im2_d = {im1_q[15], im1_q};
        end
      endcase
    end else begin
      v2_d = v2_q;
    end
  end

  // S3: saturate into the output register. Data is loaded only for valid
  // samples, so bubbles leave the last output value in place.
  always_comb begin
    v3_d  = v3_q;
    ore_d = ore_q;
    oim_d = oim_q;
    if (en) begin
      v3_d = v2_q;
      if (v2_q) begin
        ore_d = sat16(re2_q);
        oim_d = sat16(im2_q);
      end else begin
        ore_d = ore_q;
        oim_d = oim_q;
      end
    end else begin
      v3_d = v3_q;
    end
  end

  // State registers. Reset is asynchronous and discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q     <= 3'd0;
      v1_q    <= 1'b0;
      k1_q    <= 2'd0;
      sum1_q  <= 17'd0;
      diff1_q <= 17'd0;
      re1_q   <= 16'd0;
      im1_q   <= 16'd0;
      v2_q    <= 1'b0;
      re2_q   <= 17'd0;
      im2_q   <= 17'd0;
      v3_q    <= 1'b0;
      ore_q   <= 16'd0;
      oim_q   <= 16'd0;
    end else begin
      n_q     <= n_d;
      v1_q    <= v1_d;
      k1_q    <= k1_d;
      sum1_q  <= sum1_d;
      diff1_q <= diff1_d;
      re1_q   <= re1_d;
      im1_q   <= im1_d;
      v2_q    <= v2_d;
      re2_q   <= re2_d;
      im2_q   <= im2_d;
      v3_q    <= v3_d;
      ore_q   <= ore_d;
      oim_q   <= oim_d;
    end
  end

endmodule

// File: tb/tb_fft_w8_twiddle_stage.sv
// Testbench for fft_w8_twiddle_stage. Directed frames are checked against a
// plain-arithmetic reference model through a scoreboard queue, plus literal
// expectations on logged outputs.
module tb_fft_w8_twiddle_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        frame_start;
  logic [15:0] in_re;
  logic [15:0] in_im;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_re;
  logic [15:0] out_im;

  int tests = 0;
  int fails = 0;

  typedef struct { int re; int im; int cyc; } exp_t;
  typedef struct { int re; int im; } smp_t;

  exp_t exp_q[$];
  smp_t log_q[$];
  bit   strict_lat = 1'b0;

  // monitor-only state
  int   mn = 0;
  int   cyc = 0;
  bit   hold_prev = 1'b0;
  int   prev_re = 0;
  int   prev_im = 0;
  int   midx;
  exp_t me;
  smp_t ms;

  fft_w8_twiddle_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .frame_start(frame_start), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im)
  );

  always #5 clk = ~clk;

  function automatic int cmul(int x);
    return (x * 2896) / 4096;  // integer division truncates toward zero
  endfunction

  function automatic int sat(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic exp_t model(int n, int re, int im);
    exp_t r;
    int k;
    k = (n < 4) ? 0 : n - 4;
    case (k)
      1: begin r.re = cmul(re + im); r.im = cmul(im - re); end
      2: begin r.re = im; r.im = -re; end
      3: begin r.re = cmul(im - re); r.im = -cmul(re + im); end
      default: begin r.re = re; r.im = im; end
    endcase
    r.re = sat(r.re);
    r.im = sat(r.im);
    r.cyc = 0;
    return r;
  endfunction

  task automatic chk(string name, int act, int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Scoreboard: outputs, hold stability, latency, accepted-sample modelling.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mn = 0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        tests++;
        if (!(out_valid && $signed(out_re) == prev_re && $signed(out_im) == prev_im)) begin
          fails++;
          $display("FAIL hold: got v=%0b (%0d,%0d) expected v=1 (%0d,%0d)",
                   out_valid, $signed(out_re), $signed(out_im), prev_re, prev_im);
        end
      end
      if (out_valid && out_ready) begin
        ms.re = $signed(out_re);
        ms.im = $signed(out_im);
        log_q.push_back(ms);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: got (%0d,%0d) expected none", ms.re, ms.im);
        end else begin
          me = exp_q.pop_front();
          if (ms.re != me.re || ms.im != me.im) begin
            fails++;
            $display("FAIL data: got (%0d,%0d) expected (%0d,%0d)", ms.re, ms.im, me.re, me.im);
          end
          if (strict_lat) begin
            chk("latency", cyc - me.cyc, 3);
          end
        end
      end
      if (in_valid && in_ready) begin
        midx = frame_start ? 0 : mn;
        mn = (midx + 1) % 8;
        me = model(midx, $signed(in_re), $signed(in_im));
        me.cyc = cyc;
        exp_q.push_back(me);
      end
      hold_prev = out_valid && !out_ready;
      prev_re = $signed(out_re);
      prev_im = $signed(out_im);
    end
    cyc++;
  end

  task automatic send(bit fs, int re, int im);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    frame_start = fs;
    in_re = re[15:0];
    in_im = im[15:0];
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    frame_start = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic drain(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_log(string name, int i, int re, int im);
    if (i < log_q.size()) begin
      chk({name, "_re"}, log_q[i].re, re);
      chk({name, "_im"}, log_q[i].im, im);
    end else begin
      chk({name, "_present"}, log_q.size(), i + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    int tb_re[8] = '{-5, 32767, 123, -32768, -300, 32767, -32768, -32768};
    int tb_im[8] = '{7, -32768, -456, -32768, 200, 32767, 100, -32768};

    rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0;
    in_re = 16'd0; in_im = 16'd0; out_ready = 1'b1;

    // model pinning
    m = model(5, 1000, 0);
    chk("model_n5_re", m.re, 707);
    chk("model_n5_im", m.im, -707);
    m = model(7, 1000, 0);
    chk("model_n7_re", m.re, -707);
    chk("model_n7_im", m.im, -707);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    drain(3);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);

    // frame of constant 1000 + j0
    strict_lat = 1'b1;
    log_q.delete();
    send(1'b1, 1000, 0);
    for (int i = 1; i < 8; i++) send(1'b0, 1000, 0);
    drain(8);
    chk("frameA_count", log_q.size(), 8);
    for (int i = 0; i < 5; i++) chk_log("frameA_pass", i, 1000, 0);
    chk_log("frameA_n5", 5, 707, -707);
    chk_log("frameA_n6", 6, 0, -1000);
    chk_log("frameA_n7", 7, -707, -707);

    // boundary frame, with frame_start held while idle (must be ignored)
    log_q.delete();
    for (int i = 0; i < 8; i++) begin
      send(i == 0, tb_re[i], tb_im[i]);
      if (i == 2) begin
        frame_start = 1'b1;
        drain(2);
        frame_start = 1'b0;
      end
    end
    drain(8);
    chk("frameB_count", log_q.size(), 8);
    chk_log("frameB_n2", 2, 123, -456);
    chk_log("frameB_n5_sat", 5, 32767, 0);
    chk_log("frameB_n6_sat", 6, 100, 32767);
    chk_log("frameB_n7_sat", 7, 0, 32767);

    // backpressure
    strict_lat = 1'b0;
    log_q.delete();
    out_ready = 1'b0;
    fork
      begin
        send(1'b1, 1000, 0);
        for (int i = 1; i < 6; i++) send(1'b0, 1000 + i, 0);
      end
      begin
        repeat (8) @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain(8);
    chk("bp_count", log_q.size(), 6);
    for (int i = 0; i < 5; i++) chk_log("bp_order", i, 1000 + i, 0);
    chk_log("bp_n5", 5, 710, -710);

    // reset mid-frame with a full pipeline
    out_ready = 1'b0;
    send(1'b1, 1000, 0);
    send(1'b0, 1000, 0);
    send(1'b0, 1000, 0);
    drain(2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_re", out_re, 0);
    chk("midrst_out_im", out_im, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    drain(2);
    strict_lat = 1'b1;
    log_q.delete();
    for (int i = 0; i < 6; i++) send(1'b0, 1000, 0);
    drain(8);
    chk("post_rst_count", log_q.size(), 6);
    chk_log("post_rst_n4", 4, 1000, 0);
    chk_log("post_rst_n5", 5, 707, -707);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
